// File: rtl/ser4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ser4_pkg
// Brief    : Shared types and constants for the 4-bit serial frame controller.
// Revision : 1.0 - initial release
// ============================================================================
package ser4_pkg;

  localparam int DW          = 4;
  localparam int DIV_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ser4_bitdiv.sv
`default_nettype none
// ============================================================================
// Module   : ser4_bitdiv
// Brief    : Bit-period divider; o_tick marks the last cycle of each period.
// Revision : 1.0 - initial release
// ============================================================================
module ser4_bitdiv #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [7:0] c_last = 8'(DIV - 1);

  logic [7:0] r_cnt;

  assign o_tick = (r_cnt == c_last);

  // Restart holds the count at zero so the first cycle of a period is count 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_restart || o_tick) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ser4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ser4_ctrl
// Brief    : Frame controller driving an external 4-bit load/shift register.
//            Define SER4_PARITY_EN to add an even-parity bit before STOP.
// Revision : 1.0 - initial release
// ============================================================================
module ser4_ctrl
  import ser4_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ld,
  output logic          sh,
  output logic          sh_in,
  output logic [DW-1:0] d,
  input  logic          q0,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_bit;
  logic       w_tick;
  logic       w_xfer;
  logic       w_tx;
`ifdef SER4_PARITY_EN
  logic       r_par;
`endif

  ser4_bitdiv #(
    .DIV (DIV)
  ) u_bitdiv (
    .clk       (clk),
    .rst       (rst),
    .i_restart (r_state == IDLE),
    .o_tick    (w_tick)
  );

  assign in_ready = (r_state == IDLE) && !rst;
  assign w_xfer   = in_valid && in_ready;
  assign ld       = w_xfer;
  assign d        = w_xfer ? in_data : '0;
  assign sh       = (r_state == DATA) && w_tick;
  assign sh_in    = sh;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == STOP) && w_tick;

  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_next = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_tick) w_next = DATA;
      end
      DATA: begin
        w_tx = q0;
`ifdef SER4_PARITY_EN
        if (w_tick && (r_bit == 2'd3)) w_next = PARITY;
`else
        if (w_tick && (r_bit == 2'd3)) w_next = STOP;
`endif
      end
`ifdef SER4_PARITY_EN
      PARITY: begin
        w_tx = r_par;
        if (w_tick) w_next = STOP;
      end
`endif
      STOP: begin
        if (w_tick) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // tx is the registered line value of the current state, one cycle behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bit   <= 2'd0;
      tx      <= 1'b1;
    end else begin
      r_state <= w_next;
      tx      <= w_tx;
      if (sh) r_bit <= r_bit + 2'd1;
    end
  end

`ifdef SER4_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_xfer) begin
      r_par <= ^in_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ser4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser4_ctrl
// Brief    : Self-checking bench for ser4_ctrl with a behavioural shift register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ser4_ctrl;

  localparam int DIV = 4;
`ifdef SER4_PARITY_EN
  localparam int NBITS = 7;
`else
  localparam int NBITS = 6;
`endif
  localparam int NCYC = DIV * NBITS;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready, ld, sh, sh_in, q0, tx, busy, done;
  logic [3:0] d;
  logic [3:0] sreg = 4'h0;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  ser4_ctrl #(
    .DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ld       (ld),
    .sh       (sh),
    .sh_in    (sh_in),
    .d        (d),
    .q0       (q0),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always @(posedge clk) begin
    if (ld)      sreg <= d;
    else if (sh) sreg <= {sh_in, sreg[3:1]};
  end
  assign q0 = sreg[0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a word, push its expectation when accepted; waits = negedges spent waiting.
  task automatic send(input logic [3:0] w, input bit hold, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      sb.push_back(w);
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || ld) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_check();
    logic [3:0] w;
    logic [6:0] bits;
    int         nsh = 0;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    w = sb.pop_front();
    chk("ld_d", d, w);
    bits = 7'h7F;
    bits[0] = 1'b0;
    bits[4:1] = w;
`ifdef SER4_PARITY_EN
    bits[5] = ^w;
`endif
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk); #2;
      if (rst) return;
      chk("busy", busy, 1);
      chk("done", done, c == NCYC);
      chk("ld_in_frame", ld, 0);
      chk("sh", sh, (c % DIV == 0) && (c >= 2 * DIV) && (c <= 5 * DIV));
      if (sh) begin
        nsh++;
        chk("sh_in", sh_in, 1);
      end
      if ((c - 1) % DIV == DIV / 2)
        chk($sformatf("tx_bit%0d", (c - 1) / DIV), tx, bits[(c - 1) / DIV]);
      if (c == NCYC) begin
        chk("sh_count", nsh, 4);
        chk("reg_at_done", sreg, 4'hF);
      end
    end
  endtask

  initial begin : mon
    forever begin
      @(negedge clk); #2;
      if (ld) frame_check();
    end
  end

  initial begin : stim
    int w;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_ld", ld, 0);
    chk("rst_sh", sh, 0);
    chk("rst_sh_in", sh_in, 0);
    chk("rst_d", d, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single frames with fixed and random words.
    @(negedge clk); send(4'b1010, 1'b0, w); wait_idle();
    @(negedge clk); send(4'b0111, 1'b0, w); wait_idle();
    @(negedge clk); send(4'h0, 1'b0, w);    wait_idle();
    @(negedge clk); send(4'hF, 1'b0, w);    wait_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); send(4'($urandom), 1'b0, w); wait_idle();
    end

    // Back-to-back with in_valid held high.
    @(negedge clk);
    send(4'h3, 1'b1, w);
    send(4'hC, 1'b0, w);
    chk("b2b_latency", w, NCYC + 1);
    wait_idle();

    // in_valid toggling with random data during a frame.
    @(negedge clk);
    send(4'h5, 1'b0, w);
    repeat (4 * DIV) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      #1;
      chk("ready_in_frame", in_ready, 0);
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset mid-frame, then accept on the first edge after release.
    @(negedge clk);
    send(4'h9, 1'b0, w);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    send(4'h6, 1'b0, w);
    chk("post_rst_latency", w, 0);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ser4_ctrl.md
SER4_CTRL -- requirements
Module: ser4_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning clock cycles per serial bit period (legal range 2..255).
REQ-002 The block SHALL have port clk  input  1  rising-edge system clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  requester has a word on in_data.
REQ-005 The block SHALL have port in_data  input  4  word to transmit.
REQ-006 The block SHALL have port in_ready  output  1  controller accepts a word this cycle.
REQ-007 The block SHALL have port ld  output  1  load strobe to the external 4-bit shift register.
REQ-008 The block SHALL have port sh  output  1  shift-right strobe to the external register.
REQ-009 The block SHALL have port sh_in  output  1  serial fill bit into the register MSB.
REQ-010 The block SHALL have port d  output  4  parallel load value to the register.
REQ-011 The block SHALL have port q0  input  1  register bit 0, the current data bit.
REQ-012 The block SHALL have port tx  output  1  serial line, idle high.
REQ-013 The block SHALL have port busy  output  1  frame in progress.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse on the last cycle of a frame.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; it SHALL leave each non-IDLE state only after its bit counter expires.
REQ-016 in_ready SHALL be 1 exactly when state==IDLE and rst==0; a transfer occurs when in_valid && in_ready.
REQ-017 On a transfer: ld=1 and d=in_data in the same cycle, all combinational; next state START. ld=0 and d=0 otherwise.
REQ-018 Each bit period SHALL last exactly DIV cycles, timed by an 8-bit divider counter that restarts at each state entry and at each data bit.
REQ-019 START: tx=0 for DIV cycles, then DATA.
REQ-020 DATA: tx=q0; sh=1 on the last cycle of each bit period, with sh_in=1; after 4 bits, the next state is PARITY if parity is enabled, otherwise STOP.
REQ-021 A 2-bit data-bit counter SHALL count 0..3; wrap from 3 SHALL end DATA.
REQ-022 STOP: tx=1 for DIV cycles; done=1 on the final STOP cycle; next state IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Back-to-back: a word presented in the cycle after done SHALL be accepted immediately, with no idle gap beyond that cycle.
REQ-025 in_valid and in_data SHALL be ignored outside IDLE; in_data is not required to be held after the transfer.
REQ-026 tx SHALL be a registered output; all strobes (ld, sh, done) SHALL be glitch-free single-cycle pulses.

Reset
REQ-027 While rst=1: state=IDLE, tx=1, ld=0, sh=0, sh_in=0, d=0, busy=0, done=0, in_ready=0, and all counters=0.
REQ-028 Assertion mid-frame SHALL abort the frame asynchronously with no done pulse; the first accept SHALL be possible on the first clock edge after rst falls.

Configuration
REQ-029 Macro SER4_PARITY_EN: when defined, an even-parity bit over in_data SHALL be captured at the transfer and driven on tx for one DIV-cycle PARITY period between DATA and STOP.
REQ-030 When SER4_PARITY_EN is defined, the frame SHALL be 7 bit periods; when it is not defined, the PARITY state and the parity register SHALL not exist and the frame SHALL be 6 bit periods.

Structure
REQ-031 A shared package ser4_pkg SHALL hold the state enum (IDLE, START, DATA, PARITY, STOP), the data width constant DW=4, and the default DIV.
REQ-032 One sub-module, ser4_bitdiv, SHALL implement the DIV divider with a restart input and a last-cycle tick output; the FSM SHALL stay in ser4_ctrl.

Verification (DIV=4, ser4_ctrl connected to a behavioural 4-bit load/shift register)
REQ-033 Reset, then in_data=4'b1010 with in_valid for 1 cycle -> ld pulse in the transfer cycle; tx = 0,0,1,0,1,1, each held 4 cycles; done at cycle 24 after the transfer; busy high for cycles 1..24.
REQ-034 Same stimulus with SER4_PARITY_EN defined and in_data=4'b0111 -> tx = 0,1,1,1,0,1,1 (parity bit 1); done at cycle 28.
REQ-035 in_valid held high with 4'h3 then 4'hC -> second ld in the cycle after the first done; frames contiguous; tx never idles more than 1 cycle between them.
REQ-036 in_valid toggling during DATA with random in_data -> no extra ld; in_ready=0; the current frame bits are unchanged.
REQ-037 rst pulsed at cycle 10 of a frame -> tx=1, busy=0 immediately; no done pulse; a new word is accepted on the first edge after release.
REQ-038 Shift check -> exactly 4 sh pulses per frame, each on the 4th cycle of its bit, with sh_in=1; the register reads 4'b1111 at done.
